// File: rtl/stream_mux_arb.sv
// N-input valid/ready stream mux with fixed-priority or round-robin arbitration and a registered output.
// One cycle of latency; a grant is issued only when the output register is empty or draining this cycle.
module stream_mux_arb #(
  parameter int N = 4,
  parameter int n = 32,
  parameter int S = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           mode,
  input  logic [N-1:0]   in_valid,
  input  logic [N*n-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [n-1:0]   out_data,
  output logic [S-1:0]   out_sel,
  input  logic           out_ready
);

  logic         load;
  logic         gnt_any;
  logic [S-1:0] gnt;
  logic [S-1:0] ptr;
  int           idx;

  always_comb begin
    load    = !out_valid || out_ready;
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (mode) begin
      // Search ptr+1 .. ptr+N with an explicit wrap so non-power-of-two N works.
      for (int k = 1; k <= N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_any && in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt     = S'(idx);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!gnt_any && in_valid[k]) begin
          gnt_any = 1'b1;
          gnt     = S'(k);
        end
      end
    end
    in_ready = '0;
    if (nreset && load && gnt_any) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= S'(N - 1);
    end else if (load) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data <= in_data[int'(gnt)*n +: n];
        out_sel  <= gnt;
        ptr      <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: N=4 and N=3 instances, scoreboard of expected output words.
module tb_stream_mux_arb;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;

  logic [3:0]    in_valid = '0;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;

  logic [2:0]    in_valid3 = '0;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_ready3;
  logic          out_valid3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_sel3;

  typedef struct {
    int          sel;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic exp_vld = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'hB0 + i;
  end

  stream_mux_arb #(.N(4), .n(W)) dut4 (
    .clk(clk), .nreset(nreset), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.N(3), .n(W)) dut3 (
    .clk(clk), .nreset(nreset), .mode(mode),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the N=4 instance; g is the expected grant or -1 for none.
  task automatic step(input logic [3:0] v, input logic md, input logic ordy, input int g);
    exp_t e;
    in_valid = v; mode = md; out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) begin
      e.sel = g; e.data = 32'hA0 + g;
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (g >= 0) begin
      last = q.pop_front();
      exp_vld = 1'b1;
    end else if (ordy) begin
      exp_vld = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk("out_sel", 32'(out_sel), 32'(last.sel));
      chk("out_data", out_data, last.data);
    end
  endtask

  task automatic step3(input int g);
    exp_t e;
    in_valid3 = 3'b111; mode = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready3", 32'(in_ready3), 32'd1 << g);
    e.sel = g; e.data = 32'hB0 + g;
    q.push_back(e);
    @(posedge clk); #1;
    last = q.pop_front();
    chk("out_valid3", 32'(out_valid3), 32'd1);
    chk("out_sel3", 32'(out_sel3), 32'(last.sel));
    chk("out_data3", out_data3, last.data);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    exp_vld = 1'b0;
  endtask

  initial begin
    // Reset state, with all channels requesting.
    in_valid = 4'b1111; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_sel", 32'(out_sel), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    // Fixed priority.
    for (int i = 0; i < 3; i++) step(4'b1110, 1'b0, 1'b1, 1);

    // Round-robin rotation from reset.
    do_reset();
    step(4'b1111, 1'b1, 1'b1, 0);
    step(4'b1111, 1'b1, 1'b1, 1);
    step(4'b1111, 1'b1, 1'b1, 2);
    step(4'b1111, 1'b1, 1'b1, 3);
    step(4'b1111, 1'b1, 1'b1, 0);
    step(4'b1111, 1'b1, 1'b1, 1);

    // Backpressure holds word A2, then drain-and-refill on the same edge.
    step(4'b1111, 1'b1, 1'b1, 2);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, -1);
    step(4'b1111, 1'b1, 1'b1, 3);

    // Sparse wrap from ptr=3, then a lone requester.
    step(4'b1010, 1'b1, 1'b1, 1);
    step(4'b1010, 1'b1, 1'b1, 3);
    step(4'b1010, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 1'b1, 2);

    // No requester with a draining register empties it.
    step(4'b0000, 1'b1, 1'b1, -1);

    // Mode switch continues from the latest grant.
    step(4'b0011, 1'b0, 1'b1, 0);
    step(4'b0011, 1'b0, 1'b1, 0);
    step(4'b0011, 1'b1, 1'b1, 1);
    step(4'b0011, 1'b1, 1'b1, 0);
    step(4'b0011, 1'b1, 1'b1, 1);

    // Reset mid-stream while a word is stalled.
    step(4'b0001, 1'b0, 1'b1, 0);
    step(4'b1111, 1'b1, 1'b0, -1);
    #2;
    do_reset();
    step(4'b1111, 1'b1, 1'b1, 0);
    step(4'b1111, 1'b1, 1'b1, 1);
    step(4'b0000, 1'b1, 1'b1, -1);

    // N=3 wrap.
    step3(0);
    step3(1);
    step3(2);
    step3(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
